// File: rtl/inst_prefetch_unit.sv
// Instruction fetch front-end: sequential req/ack reads from program memory
// into a first-word fall-through prefetch FIFO, with redirect, halt and OOB flag.
module inst_prefetch_unit #(
  parameter int ADDR_W    = 4,
  parameter int MEM_DEPTH = 16,
  parameter int DEPTH     = 4,
  parameter int INST_W    = 32
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              fetch_oob
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W:0] PC_END   = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OOB
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   fetch_pc;
  logic [ADDR_W:0]   pc_after;
  logic [ADDR_W:0]   redir_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_after;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [INST_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic              pending;
  logic              ack_hit;
  logic              push;
  logic              pop;
  logic              issue_ok;
  logic              redir_ok;

  assign pending     = imem_req & ~imem_ack;
  assign ack_hit     = imem_req & imem_ack;
  assign push        = ack_hit & (state == S_ISSUE) & ~redirect;
  assign pop         = inst_valid & inst_ready & ~redirect;
  assign count_after = count + CW'(push) - CW'(pop);
  assign pc_after    = (push && (fetch_pc != PC_END)) ? fetch_pc + (ADDR_W+1)'(1) : fetch_pc;

  // Space is reserved at issue time, so an outstanding request can always push.
  assign issue_ok = ~halt & (count_after < CNT_FULL) & (pc_after < PC_END);
  assign redir_pc = {1'b0, redirect_pc};
  assign redir_ok = ~halt & (redir_pc < PC_END);

  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= imem_addr;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      fetch_pc  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fetch_oob <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redir_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      // A request already on the bus must complete; its data is thrown away.
      if (pending) begin
        state <= S_DRAIN;
      end else begin
        state     <= S_ISSUE;
        imem_req  <= redir_ok;
        imem_addr <= redirect_pc;
      end
    end else begin
      count    <= count_after;
      fetch_pc <= pc_after;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case (state)
        S_IDLE: begin
          state     <= S_ISSUE;
          imem_req  <= issue_ok;
          imem_addr <= pc_after[ADDR_W-1:0];
        end
        S_ISSUE: begin
          if (!pending) begin
            if (!imem_req && (fetch_pc == PC_END) && (count == '0)) begin
              state     <= S_OOB;
              fetch_oob <= 1'b1;
              imem_req  <= 1'b0;
            end else begin
              imem_req  <= issue_ok;
              imem_addr <= pc_after[ADDR_W-1:0];
            end
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            state     <= S_ISSUE;
            imem_req  <= issue_ok;
            imem_addr <= fetch_pc[ADDR_W-1:0];
          end
        end
        S_OOB: begin
          imem_req <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
